uart_cmd_tx: RTL

Host-side command transmitter for the UART register-file/ALU system. It accepts one command (opcode plus up to three operand bytes) over a valid/ready handshake. It serializes the command as back-to-back UART frames: start bit, 8 data bits LSB-first, optional parity, one stop bit. It is the initiator counterpart of the system's UART receive/command decoder and drives its `rx_in` line, both as a reusable host model and for loopback of the full system.

---
 rtl/uart_cmd_tx.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_tx.sv
// Host-side UART command transmitter: latches one opcode plus operands and
// serializes them as contiguous start/data/parity/stop frames followed by an idle gap.
module uart_cmd_tx #(
    parameter int unsigned PRESCALE  = 5,
    parameter bit          PAR_EN    = 1'b1,
    parameter bit          PAR_ODD   = 1'b0,
    parameter int unsigned IDLE_BITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_op,
    input  logic [7:0] cmd_b0,
    input  logic [7:0] cmd_b1,
    input  logic [7:0] cmd_b2,
    output logic       tx_out,
    output logic       busy,
    output logic       cmd_err
);

    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned GAP_W = (IDLE_BITS > 1) ? $clog2(IDLE_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(PRESCALE - 1);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(IDLE_BITS - 1);

    localparam logic [7:0] OP_REG_WR = 8'hAA;
    localparam logic [7:0] OP_REG_RD = 8'hBB;
    localparam logic [7:0] OP_ALU_WP = 8'hCC;
    localparam logic [7:0] OP_ALU_NP = 8'hDD;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_GAP
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [2:0]        bit_q,   bit_d;
    logic [1:0]        byte_q,  byte_d;
    logic [1:0]        last_q,  last_d;
    logic [GAP_W-1:0]  gap_q,   gap_d;
    logic [3:0][7:0]   data_q,  data_d;
    logic              tx_q,    tx_d;
    logic              ready_q, ready_d;
    logic              busy_q,  busy_d;
    logic              err_q,   err_d;

    logic              op_ok_c;
    logic [1:0]        op_last_c;
    logic              bit_end_c;
    logic              accept_c;
    logic [7:0]        cur_byte_c;
    logic              parity_c;

    // Opcode decode: index of the last byte to send, counting the opcode as byte 0
    always_comb begin
        op_ok_c   = 1'b1;
        op_last_c = 2'd0;
        case (cmd_op)
            OP_REG_WR: op_last_c = 2'd2;
            OP_REG_RD: op_last_c = 2'd1;
            OP_ALU_WP: op_last_c = 2'd3;
            OP_ALU_NP: op_last_c = 2'd1;
            default:   op_ok_c   = 1'b0;
        endcase
    end

    assign bit_end_c = (cnt_q == '0);
    assign accept_c  = cmd_valid & ready_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        last_d  = last_q;
        gap_d   = gap_q;
        data_d  = data_q;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    if (op_ok_c) begin
                        state_d = S_START;
                        cnt_d   = CNT_RELOAD;
                        byte_d  = 2'd0;
                        last_d  = op_last_c;
                        data_d  = {cmd_b2, cmd_b1, cmd_b0, cmd_op};
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_START: begin
                if (bit_end_c) begin
                    state_d = S_DATA;
                    cnt_d   = CNT_RELOAD;
                    bit_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end_c) begin
                    cnt_d = CNT_RELOAD;
                    if (bit_q == 3'd7) begin
                        state_d = PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_PARITY: begin
                if (bit_end_c) begin
                    state_d = S_STOP;
                    cnt_d   = CNT_RELOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_STOP: begin
                if (bit_end_c) begin
                    cnt_d = CNT_RELOAD;
                    if (byte_q == last_q) begin
                        state_d = S_GAP;
                        gap_d   = '0;
                    end else begin
                        state_d = S_START;
                        byte_d  = byte_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_GAP: begin
                if (bit_end_c) begin
                    cnt_d = CNT_RELOAD;
                    if (gap_q == GAP_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Line level for the upcoming cycle, derived from next-state so tx_out is a flop
    assign cur_byte_c = data_d[byte_d];
    assign parity_c   = (^cur_byte_c) ^ PAR_ODD;

    always_comb begin
        tx_d    = 1'b1;
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = cur_byte_c[bit_d];
            S_PARITY: tx_d = parity_c;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 2'd0;
            last_q  <= 2'd0;
            gap_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            last_q  <= last_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign tx_out    = tx_q;
    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign cmd_err   = err_q;

endmodule
